// File: rtl/seg7_anim_sequencer.sv
// Animation sequencer for the seven-segment display datapath.
// It debounces a "next" pushbutton, runs the frame timer and steps the frame index
// within the limit of the current animation. With auto-advance enabled it moves to
// the next animation after a set number of complete frame loops.
// The animation and frame outputs drive the seg7 decoder directly. The timer
// counter is exported for the debug pins.
module seg7_anim_sequencer #(
  parameter logic [23:0] MAX_COUNT       = 24'd10_000_000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [2:0]  LOOPS_PER_ANI   = 3'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        btn_next,
  input  logic        auto_en,
  input  logic [7:0]  speed,
  output logic [2:0]  animation,
  output logic [3:0]  frame,
  output logic        frame_tick,
  output logic        ani_change,
  output logic [23:0] timer
);

  localparam logic [15:0] DCNT_LAST  = DEBOUNCE_CYCLES - 16'd1;
  localparam logic [2:0]  LOOPS_LAST = LOOPS_PER_ANI - 3'd1;
  localparam logic [2:0]  ANI_LAST   = 3'd5;

  // Button path
  logic [1:0]  sync_q, sync_d;
  logic        btn_s;
  logic        db_q, db_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic        press;

  // Frame timer
  logic [23:0] compare;
  logic [23:0] timer_q, timer_d;
  logic        tick;
  logic        timer_over;

  // Sequencing state
  logic [2:0]  ani_q, ani_d;
  logic [3:0]  frame_q, frame_d;
  logic [2:0]  loops_q, loops_d;
  logic        frame_tick_q, frame_tick_d;
  logic        ani_change_q, ani_change_d;

  logic [3:0]  limit;
  logic        at_limit;
  logic        loops_done;
  logic        auto_adv;
  logic        advance;
  logic [2:0]  ani_next;

  // Last valid frame index of each animation. Codes 6 and 7 never occur.
  function automatic logic [3:0] frame_limit(input logic [2:0] ani);
    case (ani)
      3'd0:             frame_limit = 4'd9;
      3'd1, 3'd2, 3'd3: frame_limit = 4'd6;
      default:          frame_limit = 4'd5;
    endcase
  endfunction

  assign btn_s = sync_q[1];

  // Two-flop synchronizer and the debouncer. A level change is accepted after
  // DEBOUNCE_CYCLES consecutive cycles that disagree with the debounced level.
  always_comb begin
    sync_d = {sync_q[0], btn_next};
    db_d   = db_q;
    dcnt_d = dcnt_q;
    press  = 1'b0;
    if (btn_s == db_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      db_d   = btn_s;
      dcnt_d = '0;
      // A press is the rising edge of the debounced level. A release produces no event.
      press  = btn_s;
    end else begin
      dcnt_d = dcnt_q + 16'd1;
    end
  end

  // Frame period select. speed is used directly each cycle, so changing it needs no handshake.
  assign compare    = (speed == 8'd0) ? MAX_COUNT : {6'b0, speed, 10'b0};
  assign tick       = (timer_q == compare);
  assign timer_over = (timer_q >= compare);

  assign limit      = frame_limit(ani_q);
  assign at_limit   = (frame_q == limit);
  assign loops_done = (loops_q == LOOPS_LAST);
  assign auto_adv   = auto_en && tick && at_limit && loops_done;
  assign advance    = press || auto_adv;
  assign ani_next   = (ani_q == ANI_LAST) ? 3'd0 : ani_q + 3'd1;

  // Timer next state. When the timer is above compare, which only happens after a
  // speed change, it restarts without a tick, so the counter can never wrap at 2^24.
  always_comb begin
    timer_d = timer_q + 24'd1;
    if (advance || timer_over) begin
      timer_d = '0;
    end
  end

  // Frame and animation next state. An advance takes precedence over the frame step,
  // so a press that coincides with a tick gives exactly one advance.
  always_comb begin
    ani_d        = ani_q;
    frame_d      = frame_q;
    loops_d      = loops_q;
    frame_tick_d = 1'b0;
    ani_change_d = 1'b0;
    if (advance) begin
      ani_d        = ani_next;
      frame_d      = '0;
      loops_d      = '0;
      ani_change_d = 1'b1;
    end else if (tick) begin
      frame_tick_d = 1'b1;
      if (at_limit) begin
        frame_d = '0;
        // loops saturates at the last value while auto-advance is off.
        if (!loops_done) begin
          loops_d = loops_q + 3'd1;
        end
      end else begin
        frame_d = frame_q + 4'd1;
      end
    end
  end

  // State register. While ena is low every register holds its value (including the
  // synchronizer) and both event pulses are forced low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      db_q         <= 1'b0;
      dcnt_q       <= '0;
      timer_q      <= '0;
      ani_q        <= '0;
      frame_q      <= '0;
      loops_q      <= '0;
      frame_tick_q <= 1'b0;
      ani_change_q <= 1'b0;
    end else if (ena) begin
      sync_q       <= sync_d;
      db_q         <= db_d;
      dcnt_q       <= dcnt_d;
      timer_q      <= timer_d;
      ani_q        <= ani_d;
      frame_q      <= frame_d;
      loops_q      <= loops_d;
      frame_tick_q <= frame_tick_d;
      ani_change_q <= ani_change_d;
    end else begin
      frame_tick_q <= 1'b0;
      ani_change_q <= 1'b0;
    end
  end

  assign animation  = ani_q;
  assign frame      = frame_q;
  assign frame_tick = frame_tick_q;
  assign ani_change = ani_change_q;
  assign timer      = timer_q;

endmodule

// File: tb/tb_seg7_anim_sequencer.sv
// Testbench for seg7_anim_sequencer. The stimulus queues the expected event records
// {animation, frame, frame_tick, ani_change, spacing}. A monitor pops one record on
// every frame_tick or ani_change pulse and compares it with the outputs.
module tb_seg7_anim_sequencer;

  localparam logic [7:0] SPD_SLOW = 8'hFF;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        btn_next;
  logic        auto_en;
  logic [7:0]  speed;
  logic [2:0]  animation;
  logic [3:0]  frame;
  logic        frame_tick;
  logic        ani_change;
  logic [23:0] timer;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cyc = 0;
  int evt_n = 0;

  typedef struct packed {
    logic [2:0] ani;
    logic [3:0] frm;
    logic       ft;
    logic       ac;
    int         gap;
  } exp_t;

  exp_t sb_q[$];

  seg7_anim_sequencer #(
    .MAX_COUNT       (24'd3),
    .DEBOUNCE_CYCLES (16'd4),
    .LOOPS_PER_ANI   (3'd2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_next   (btn_next),
    .auto_en    (auto_en),
    .speed      (speed),
    .animation  (animation),
    .frame      (frame),
    .frame_tick (frame_tick),
    .ani_change (ani_change),
    .timer      (timer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output event must match the next queued record. A gap of 0 leaves
  // the spacing unchecked.
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (rst_n === 1'b1 && (frame_tick === 1'b1 || ani_change === 1'b1)) begin
      tests++;
      evt_n++;
      g = cyc - last_cyc;
      last_cyc = cyc;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event_%0d: got ani=%0d frame=%0d tick=%0b chg=%0b, required no event",
                 evt_n, animation, frame, frame_tick, ani_change);
      end else begin
        e = sb_q.pop_front();
        if (animation !== e.ani || frame !== e.frm || frame_tick !== e.ft ||
            ani_change !== e.ac || (e.gap != 0 && g != e.gap)) begin
          fails++;
          $display("FAIL event_%0d: got ani=%0d frame=%0d tick=%0b chg=%0b gap=%0d, required ani=%0d frame=%0d tick=%0b chg=%0b gap=%0d",
                   evt_n, animation, frame, frame_tick, ani_change, g,
                   e.ani, e.frm, e.ft, e.ac, e.gap);
        end
      end
    end
  end

  task automatic push_evt(input logic [2:0] a, input logic [3:0] f,
                          input logic ft, input logic ac, input int gap);
    exp_t e;
    e.ani = a;
    e.frm = f;
    e.ft  = ft;
    e.ac  = ac;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Wait until the monitor has consumed every queued record, bounded in cycles.
  task automatic wait_empty(input int bound, input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending events, required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  // A clean press: high for 8 cycles, then low for 8 cycles so the release settles.
  task automatic press(input logic [2:0] new_ani);
    push_evt(new_ani, 4'd0, 1'b0, 1'b1, 0);
    btn_next = 1'b1;
    repeat (8) @(negedge clk);
    btn_next = 1'b0;
    repeat (8) @(negedge clk);
    wait_empty(4, "press");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    ena      = 1'b1;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    speed    = 8'h00;

    // Reset state
    #22;
    check("rst_animation", 32'(animation), 32'd0);
    check("rst_frame", 32'(frame), 32'd0);
    check("rst_timer", 32'(timer), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_ani_change", 32'(ani_change), 32'd0);

    // Free run: a tick every 4 cycles, frame goes 0..9 and wraps, animation stays 0
    for (int k = 1; k <= 12; k++) push_evt(3'd0, 4'(k % 10), 1'b1, 1'b0, (k == 1) ? 0 : 4);
    @(negedge clk);
    rst_n = 1'b1;
    wait_empty(100, "free_run");
    speed = SPD_SLOW;

    // Short pulse (3 cycles) is ignored
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (20) @(negedge clk);
    check("short_pulse_animation", 32'(animation), 32'd0);

    // Long press: animation changes on the 6th edge
    push_evt(3'd1, 4'd0, 1'b0, 1'b1, 0);
    btn_next = 1'b1;
    repeat (5) @(negedge clk);
    check("press_edge5_animation", 32'(animation), 32'd0);
    @(negedge clk);
    check("press_edge6_animation", 32'(animation), 32'd1);
    check("press_edge6_frame", 32'(frame), 32'd0);
    check("press_edge6_timer", 32'(timer), 32'd0);
    repeat (4) @(negedge clk);
    btn_next = 1'b0;
    repeat (12) @(negedge clk);
    check("release_animation", 32'(animation), 32'd1);

    // Presses wrap 5 -> 0, then continue on to animation 4
    for (int i = 2; i <= 10; i++) begin
      press(3'(i % 6));
      if (i == 6) check("six_press_wrap", 32'(animation), 32'd0);
    end

    // Auto-advance 4 -> 5 -> 0 after two loops of each
    for (int a = 4; a <= 5; a++) begin
      for (int k = 1; k <= 11; k++)
        push_evt(3'(a), 4'(k % 6), 1'b1, 1'b0, (a == 4 && k == 1) ? 0 : 4);
      push_evt((a == 5) ? 3'd0 : 3'd5, 4'd0, 1'b0, 1'b1, 4);
    end
    for (int k = 1; k <= 15; k++) push_evt(3'd0, 4'(k % 10), 1'b1, 1'b0, 4);
    speed   = 8'h00;
    auto_en = 1'b1;
    wait_empty(200, "auto_advance");
    // Clearing auto_en mid-loop: the next wrap at frame 9 does not advance
    auto_en = 1'b0;
    for (int k = 16; k <= 22; k++) push_evt(3'd0, 4'(k % 10), 1'b1, 1'b0, 4);
    wait_empty(60, "auto_off");
    speed = SPD_SLOW;

    // Collision: a press lands on the tick edge with frame 6 on animation 1
    press(3'd1);
    speed   = 8'h00;
    auto_en = 1'b1;
    for (int k = 1; k <= 6; k++) push_evt(3'd1, 4'(k), 1'b1, 1'b0, (k == 1) ? 0 : 4);
    push_evt(3'd2, 4'd0, 1'b0, 1'b1, 4);
    repeat (23) @(posedge clk);
    @(negedge clk);
    btn_next = 1'b1;
    wait_empty(60, "collision");
    speed   = SPD_SLOW;
    auto_en = 1'b0;
    repeat (4) @(negedge clk);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);

    // speed = 1: period of 1025 cycles
    speed = 8'h01;
    push_evt(3'd2, 4'd1, 1'b1, 1'b0, 0);
    push_evt(3'd2, 4'd2, 1'b1, 1'b0, 1025);
    wait_empty(2200, "speed_01");
    // Drop speed from 0x80 to 0x01 with timer at 2000: timer restarts without a tick
    speed = 8'h80;
    n = 0;
    while (timer !== 24'd2000 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("timer_reach_2000", 32'(timer), 32'd2000);
    speed = 8'h01;
    @(negedge clk);
    check("speed_drop_timer", 32'(timer), 32'd0);
    check("speed_drop_tick", 32'(frame_tick), 32'd0);
    check("speed_drop_frame", 32'(frame), 32'd2);

    // ena low for 20 cycles: everything frozen and the press is dropped
    speed = SPD_SLOW;
    ena   = 1'b0;
    btn_next = 1'b1;
    repeat (10) @(negedge clk);
    btn_next = 1'b0;
    repeat (10) @(negedge clk);
    check("ena_low_timer", 32'(timer), 32'd0);
    check("ena_low_frame", 32'(frame), 32'd2);
    check("ena_low_animation", 32'(animation), 32'd2);
    ena = 1'b1;
    repeat (20) @(negedge clk);
    check("ena_resume_timer", 32'(timer), 32'd20);
    check("ena_resume_animation", 32'(animation), 32'd2);

    // Asynchronous reset from animation 3, frame 4
    press(3'd3);
    speed = 8'h00;
    for (int k = 1; k <= 4; k++) push_evt(3'd3, 4'(k), 1'b1, 1'b0, (k == 1) ? 0 : 4);
    wait_empty(40, "pre_reset");
    check("pre_reset_animation", 32'(animation), 32'd3);
    check("pre_reset_frame", 32'(frame), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_animation", 32'(animation), 32'd0);
    check("async_rst_frame", 32'(frame), 32'd0);
    check("async_rst_timer", 32'(timer), 32'd0);
    check("async_rst_frame_tick", 32'(frame_tick), 32'd0);
    check("async_rst_ani_change", 32'(ani_change), 32'd0);
    speed = SPD_SLOW;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_timer", 32'(timer), 32'd10);
    check("post_reset_animation", 32'(animation), 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
